hms_counter: RTL

HMS_COUNTER -- requirements
Module: hms_counter

---
 rtl/hms_pkg.sv | 25 ++
 rtl/bcd_mod_counter.sv | 50 +++++
 rtl/hms_counter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hms_pkg.sv
// Shared state encodings, digit limits and BCD field widths for the
// hours/minutes/seconds counter.
package hms_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_SET_HR  = 2'd2,
    ST_SET_MIN = 2'd3
  } state_e;

  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HR_MAX    = 23;

  localparam int ONES_W    = 4;
  localparam int MS_TENS_W = 3;
  localparam int HR_TENS_W = 2;

  function automatic logic [6:0] bcd_to_bin(input logic [2:0] tens,
                                            input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MODULUS-1. Carry-out fires in the same
// cycle as the wrapping increment so chained counters roll over together.
module bcd_mod_counter
  import hms_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int TENS_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [TENS_W-1:0] o_tens,
  output logic [ONES_W-1:0] o_ones,
  output logic              o_carry
);

  localparam logic [TENS_W-1:0] TENS_MAX = TENS_W'((MODULUS - 1) / 10);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'((MODULUS - 1) % 10);

  logic [TENS_W-1:0] r_tens;
  logic [ONES_W-1:0] r_ones;
  logic              w_at_max;

  assign w_at_max = (r_tens == TENS_MAX) && (r_ones == ONES_MAX);
  assign o_carry  = i_inc && w_at_max && !i_clr;
  assign o_tens   = r_tens;
  assign o_ones   = r_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_ones == ONES_W'(9)) begin
        r_tens <= r_tens + TENS_W'(1);
        r_ones <= '0;
      end else begin
        r_ones <= r_ones + ONES_W'(1);
      end
    end
  end

endmodule

// File: rtl/hms_counter.sv
// 24-hour BCD clock with run/pause and hour/minute set modes.
// Optional alarm output is built only when macro HMS_ALARM_EN is defined.
module hms_counter
  import hms_pkg::*;
#(
  parameter int CLEAR_ON_SET = 1,
  parameter int ALARM_LEN    = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_1Hz,
  input  logic                 mode_btn,
  input  logic                 inc_btn,
  input  logic                 pause_btn,
`ifdef HMS_ALARM_EN
  input  logic [4:0]           alarm_hh,
  input  logic [5:0]           alarm_mm,
  input  logic                 alarm_en,
  output logic                 alarm_out,
`endif
  output logic [HR_TENS_W-1:0] hour_t,
  output logic [ONES_W-1:0]    hour_o,
  output logic [MS_TENS_W-1:0] min_t,
  output logic [ONES_W-1:0]    min_o,
  output logic [MS_TENS_W-1:0] sec_t,
  output logic [ONES_W-1:0]    sec_o,
  output logic [1:0]           state,
  output logic                 sec_pulse
);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_enter_set;
  logic   w_sec_clr;

  logic   r_clk1_s;
  logic   r_clk1_d;
  logic   w_tick;
  logic   w_run_tick;
  logic   r_sec_pulse;

  logic   w_sec_co;
  logic   w_min_co;
  logic   w_min_inc;
  logic   w_hr_inc;
  logic   w_hr_carry_unused;

  // clk_1Hz is sampled once, then compared with its previous sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk1_s    <= 1'b0;
      r_clk1_d    <= 1'b0;
      r_sec_pulse <= 1'b0;
    end else begin
      r_clk1_s    <= clk_1Hz;
      r_clk1_d    <= r_clk1_s;
      r_sec_pulse <= w_run_tick;
    end
  end

  assign w_tick     = r_clk1_s && !r_clk1_d;
  assign w_run_tick = w_tick && (r_state == ST_RUN);
  assign sec_pulse  = r_sec_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // mode_btn is checked first so it wins over a coincident pause_btn.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mode_btn) begin
          w_state_nxt = ST_SET_HR;
          w_enter_set = 1'b1;
        end else if (pause_btn) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (mode_btn) begin
          w_state_nxt = ST_SET_HR;
          w_enter_set = 1'b1;
        end else if (pause_btn) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SET_HR:  if (mode_btn) w_state_nxt = ST_SET_MIN;
      ST_SET_MIN: if (mode_btn) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  assign state     = r_state;
  assign w_sec_clr = w_enter_set && (CLEAR_ON_SET != 0);

  // Minute carry only propagates to hours when driven by a seconds wrap,
  // never when the minute was bumped by inc_btn in set mode.
  assign w_min_inc = w_sec_co || ((r_state == ST_SET_MIN) && inc_btn);
  assign w_hr_inc  = (w_min_co && w_sec_co) || ((r_state == ST_SET_HR) && inc_btn);

  bcd_mod_counter #(.MODULUS(SEC_MAX + 1), .TENS_W(MS_TENS_W)) u_sec (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (w_run_tick),
    .i_clr   (w_sec_clr),
    .o_tens  (sec_t),
    .o_ones  (sec_o),
    .o_carry (w_sec_co)
  );

  bcd_mod_counter #(.MODULUS(MIN_MAX + 1), .TENS_W(MS_TENS_W)) u_min (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (w_min_inc),
    .i_clr   (1'b0),
    .o_tens  (min_t),
    .o_ones  (min_o),
    .o_carry (w_min_co)
  );

  // Day rollover has no consumer.
  bcd_mod_counter #(.MODULUS(HR_MAX + 1), .TENS_W(HR_TENS_W)) u_hr (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (w_hr_inc),
    .i_clr   (1'b0),
    .o_tens  (hour_t),
    .o_ones  (hour_o),
    .o_carry (w_hr_carry_unused)
  );

`ifdef HMS_ALARM_EN
  localparam logic [7:0] ALARM_LEN_C = 8'(ALARM_LEN);

  logic       r_alarm;
  logic [7:0] r_alarm_cnt;
  logic       w_any_btn;
  logic       w_alarm_hit;

  assign w_any_btn   = mode_btn || inc_btn || pause_btn;
  assign w_alarm_hit = r_sec_pulse && (r_state == ST_RUN) && alarm_en &&
                       (bcd_to_bin({1'b0, hour_t}, hour_o) == {2'b00, alarm_hh}) &&
                       (bcd_to_bin(min_t, min_o) == {1'b0, alarm_mm}) &&
                       (sec_t == '0) && (sec_o == '0);

  // Alarm then stays up for ALARM_LEN further seconds unless cancelled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else if (r_alarm && (w_any_btn || !alarm_en)) begin
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else if (w_alarm_hit) begin
      r_alarm     <= 1'b1;
      r_alarm_cnt <= ALARM_LEN_C;
    end else if (r_alarm && r_sec_pulse) begin
      if (r_alarm_cnt <= 8'd1) r_alarm <= 1'b0;
      r_alarm_cnt <= r_alarm_cnt - 8'd1;
    end
  end

  assign alarm_out = r_alarm;
`endif

endmodule
